mem_access: RTL and testbench

- Consumer end of the cushion register.
- Takes the registered memory-read and memory-write requests from the cushion stage and runs them on the data-memory valid/ready request/response interface.
- Extracts and sign-extends load data, and produces the register-writeback pair for the next stage.
- Holds the upstream pipeline by asserting STALL while a memory transaction is outstanding.

---
 rtl/mem_access.sv | 188 ++++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory stage behind the cushion register.
// Runs the latched load/store requests on the data-memory valid/ready
// interface. It extracts and sign-extends load data and registers the writeback pair.
// STALL holds the upstream stages while a memory transaction is in flight.
//
// Ports:
//   CLK, RST (sync, active-low), FLUSH
//   STALL                       - hold request to cushion/upstream
//   CUSHION_REG_W_*             - non-memory writeback pair
//   CUSHION_MEM_R_* / _W_*      - load / store requests from cushion
//   DMEM_RDREQ_* / DMEM_RDDATA* - read request / response channel
//   DMEM_WRREQ_*                - write request channel
//   MEM_REG_W_RD/DATA           - registered writeback pair
module mem_access (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  output logic        STALL,
  input  logic [4:0]  CUSHION_REG_W_RD,
  input  logic [31:0] CUSHION_REG_W_DATA,
  input  logic        CUSHION_MEM_R_VALID,
  input  logic [4:0]  CUSHION_MEM_R_RD,
  input  logic [31:0] CUSHION_MEM_R_ADDR,
  input  logic [3:0]  CUSHION_MEM_R_STRB,
  input  logic        CUSHION_MEM_R_SIGNED,
  input  logic        CUSHION_MEM_W_VALID,
  input  logic [31:0] CUSHION_MEM_W_ADDR,
  input  logic [3:0]  CUSHION_MEM_W_STRB,
  input  logic [31:0] CUSHION_MEM_W_DATA,
  output logic        DMEM_RDREQ_VALID,
  output logic [31:0] DMEM_RDREQ_ADDR,
  input  logic        DMEM_RDREQ_READY,
  input  logic        DMEM_RDDATA_VALID,
  input  logic [31:0] DMEM_RDDATA,
  output logic        DMEM_WRREQ_VALID,
  output logic [31:0] DMEM_WRREQ_ADDR,
  output logic [3:0]  DMEM_WRREQ_STRB,
  output logic [31:0] DMEM_WRREQ_DATA,
  input  logic        DMEM_WRREQ_READY,
  output logic [4:0]  MEM_REG_W_RD,
  output logic [31:0] MEM_REG_W_DATA
);

  typedef enum logic [2:0] {IDLE, RREQ, RWAIT, WREQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic        w_pend_q, w_pend_d;
  logic [4:0]  r_rd_q, r_rd_d;
  logic [31:0] r_addr_q, r_addr_d;
  logic [3:0]  r_strb_q, r_strb_d;
  logic        r_signed_q, r_signed_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [31:0] w_data_q, w_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic mem_req;
  assign mem_req = CUSHION_MEM_R_VALID | CUSHION_MEM_W_VALID;

  // Align the lowest enabled lane to bit 0, then size/extend by mask shape.
  // Masks that are not a byte, aligned half or full word pass the raw word.
  function automatic logic [31:0] extract(input logic [3:0] strb,
                                          input logic sgn,
                                          input logic [31:0] data);
    logic [4:0]  shift;
    logic [31:0] v;
    shift = strb[0] ? 5'd0 : strb[1] ? 5'd8 : strb[2] ? 5'd16 :
            strb[3] ? 5'd24 : 5'd0;
    v = data >> shift;
    case (strb)
      4'b0001, 4'b0010, 4'b0100, 4'b1000:
        extract = {{24{sgn & v[7]}}, v[7:0]};
      4'b0011, 4'b1100:
        extract = {{16{sgn & v[15]}}, v[15:0]};
      default: extract = data;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    kill_d     = kill_q;
    w_pend_d   = w_pend_q;
    r_rd_d     = r_rd_q;
    r_addr_d   = r_addr_q;
    r_strb_d   = r_strb_q;
    r_signed_d = r_signed_q;
    w_addr_d   = w_addr_q;
    w_strb_d   = w_strb_q;
    w_data_d   = w_data_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (FLUSH) begin
          wb_rd_d = 5'd0;
        end else if (mem_req) begin
          r_rd_d     = CUSHION_MEM_R_RD;
          r_addr_d   = CUSHION_MEM_R_ADDR;
          r_strb_d   = CUSHION_MEM_R_STRB;
          r_signed_d = CUSHION_MEM_R_SIGNED;
          w_pend_d   = CUSHION_MEM_W_VALID;
          w_addr_d   = CUSHION_MEM_W_ADDR;
          w_strb_d   = CUSHION_MEM_W_STRB;
          w_data_d   = CUSHION_MEM_W_DATA;
          wb_rd_d    = 5'd0;
          state_d    = CUSHION_MEM_R_VALID ? RREQ : WREQ;
        end else begin
          wb_rd_d   = CUSHION_REG_W_RD;
          wb_data_d = CUSHION_REG_W_DATA;
        end
      end
      RREQ: begin
        if (FLUSH) kill_d = 1'b1;
        if (DMEM_RDREQ_READY) state_d = RWAIT;
      end
      RWAIT: begin
        if (FLUSH) kill_d = 1'b1;
        if (DMEM_RDDATA_VALID) begin
          // A flush arriving with the data kills it too.
          wb_rd_d   = (kill_q | FLUSH) ? 5'd0 : r_rd_q;
          wb_data_d = extract(r_strb_q, r_signed_q, DMEM_RDDATA);
          state_d   = w_pend_q ? WREQ : DONE;
        end
      end
      WREQ: begin
        if (FLUSH) kill_d = 1'b1;
        if (DMEM_WRREQ_READY) state_d = DONE;
      end
      DONE: begin
        // Load result was presented during DONE; retire it now.
        wb_rd_d = 5'd0;
        kill_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      w_pend_q   <= 1'b0;
      r_rd_q     <= '0;
      r_addr_q   <= '0;
      r_strb_q   <= '0;
      r_signed_q <= 1'b0;
      w_addr_q   <= '0;
      w_strb_q   <= '0;
      w_data_q   <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      kill_q     <= kill_d;
      w_pend_q   <= w_pend_d;
      r_rd_q     <= r_rd_d;
      r_addr_q   <= r_addr_d;
      r_strb_q   <= r_strb_d;
      r_signed_q <= r_signed_d;
      w_addr_q   <= w_addr_d;
      w_strb_q   <= w_strb_d;
      w_data_q   <= w_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Request channels decode straight from the state flop; address/data
  // come from the latched registers so they stay stable until READY.
  assign DMEM_RDREQ_VALID = (state_q == RREQ);
  assign DMEM_RDREQ_ADDR  = r_addr_q;
  assign DMEM_WRREQ_VALID = (state_q == WREQ);
  assign DMEM_WRREQ_ADDR  = w_addr_q;
  assign DMEM_WRREQ_STRB  = w_strb_q;
  assign DMEM_WRREQ_DATA  = w_data_q;
  assign MEM_REG_W_RD     = wb_rd_q;
  assign MEM_REG_W_DATA   = wb_data_q;

  // Held low while RST is asserted so upstream never sees a stall from
  // stale request inputs during reset.
  assign STALL = RST & ((state_q == RREQ) | (state_q == RWAIT) |
                        (state_q == WREQ) | ((state_q == IDLE) & mem_req));

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: reset, passthrough, loads of each
// extraction shape, back-pressure, combined load+store and flush cases.
module tb_mem_access;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic        STALL;
  logic [4:0]  CUSHION_REG_W_RD = '0;
  logic [31:0] CUSHION_REG_W_DATA = '0;
  logic        CUSHION_MEM_R_VALID = 1'b0;
  logic [4:0]  CUSHION_MEM_R_RD = '0;
  logic [31:0] CUSHION_MEM_R_ADDR = '0;
  logic [3:0]  CUSHION_MEM_R_STRB = '0;
  logic        CUSHION_MEM_R_SIGNED = 1'b0;
  logic        CUSHION_MEM_W_VALID = 1'b0;
  logic [31:0] CUSHION_MEM_W_ADDR = '0;
  logic [3:0]  CUSHION_MEM_W_STRB = '0;
  logic [31:0] CUSHION_MEM_W_DATA = '0;
  logic        DMEM_RDREQ_VALID;
  logic [31:0] DMEM_RDREQ_ADDR;
  logic        DMEM_RDREQ_READY = 1'b0;
  logic        DMEM_RDDATA_VALID = 1'b0;
  logic [31:0] DMEM_RDDATA = '0;
  logic        DMEM_WRREQ_VALID;
  logic [31:0] DMEM_WRREQ_ADDR;
  logic [3:0]  DMEM_WRREQ_STRB;
  logic [31:0] DMEM_WRREQ_DATA;
  logic        DMEM_WRREQ_READY = 1'b0;
  logic [4:0]  MEM_REG_W_RD;
  logic [31:0] MEM_REG_W_DATA;

  int n_cmp = 0;
  int n_err = 0;
  int rd_hs = 0;
  int wr_hs = 0;
  int hs0;

  mem_access dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .STALL(STALL),
    .CUSHION_REG_W_RD(CUSHION_REG_W_RD), .CUSHION_REG_W_DATA(CUSHION_REG_W_DATA),
    .CUSHION_MEM_R_VALID(CUSHION_MEM_R_VALID), .CUSHION_MEM_R_RD(CUSHION_MEM_R_RD),
    .CUSHION_MEM_R_ADDR(CUSHION_MEM_R_ADDR), .CUSHION_MEM_R_STRB(CUSHION_MEM_R_STRB),
    .CUSHION_MEM_R_SIGNED(CUSHION_MEM_R_SIGNED),
    .CUSHION_MEM_W_VALID(CUSHION_MEM_W_VALID), .CUSHION_MEM_W_ADDR(CUSHION_MEM_W_ADDR),
    .CUSHION_MEM_W_STRB(CUSHION_MEM_W_STRB), .CUSHION_MEM_W_DATA(CUSHION_MEM_W_DATA),
    .DMEM_RDREQ_VALID(DMEM_RDREQ_VALID), .DMEM_RDREQ_ADDR(DMEM_RDREQ_ADDR),
    .DMEM_RDREQ_READY(DMEM_RDREQ_READY), .DMEM_RDDATA_VALID(DMEM_RDDATA_VALID),
    .DMEM_RDDATA(DMEM_RDDATA), .DMEM_WRREQ_VALID(DMEM_WRREQ_VALID),
    .DMEM_WRREQ_ADDR(DMEM_WRREQ_ADDR), .DMEM_WRREQ_STRB(DMEM_WRREQ_STRB),
    .DMEM_WRREQ_DATA(DMEM_WRREQ_DATA), .DMEM_WRREQ_READY(DMEM_WRREQ_READY),
    .MEM_REG_W_RD(MEM_REG_W_RD), .MEM_REG_W_DATA(MEM_REG_W_DATA)
  );

  always #5 CLK = ~CLK;

  // Count accepted requests independently of the directed sequence.
  always @(posedge CLK) begin
    if (RST && DMEM_RDREQ_VALID && DMEM_RDREQ_READY) rd_hs <= rd_hs + 1;
    if (RST && DMEM_WRREQ_VALID && DMEM_WRREQ_READY) wr_hs <= wr_hs + 1;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_mem;
    CUSHION_MEM_R_VALID = 1'b0;
    CUSHION_MEM_W_VALID = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] addr,
                          input logic [3:0] strb, input logic sgn);
    CUSHION_MEM_R_VALID  = 1'b1;
    CUSHION_MEM_R_RD     = rd;
    CUSHION_MEM_R_ADDR   = addr;
    CUSHION_MEM_R_STRB   = strb;
    CUSHION_MEM_R_SIGNED = sgn;
  endtask

  // Zero-wait load: IDLE -> RREQ -> RWAIT -> DONE, checked in DONE.
  task automatic quick_load(input string tag, input logic [3:0] strb,
                            input logic sgn, input logic [31:0] word,
                            input logic [31:0] exp);
    set_load(5'd12, 32'h40, strb, sgn);
    DMEM_RDREQ_READY = 1'b1; DMEM_RDDATA_VALID = 1'b1; DMEM_RDDATA = word;
    tick; clr_mem;
    tick; tick;
    #1;
    chk({tag, "_rd"}, {27'd0, MEM_REG_W_RD}, 32'd12);
    chk({tag, "_data"}, MEM_REG_W_DATA, exp);
    tick;
    DMEM_RDREQ_READY = 1'b0; DMEM_RDDATA_VALID = 1'b0;
  endtask

  initial begin
    // Reset with random inputs.
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {CUSHION_MEM_R_VALID, CUSHION_MEM_W_VALID, FLUSH,
       DMEM_RDREQ_READY, DMEM_RDDATA_VALID, DMEM_WRREQ_READY} = 6'($urandom);
      CUSHION_REG_W_RD = 5'($urandom); CUSHION_REG_W_DATA = $urandom;
      CUSHION_MEM_R_ADDR = $urandom; CUSHION_MEM_W_DATA = $urandom;
      DMEM_RDDATA = $urandom;
      tick;
    end
    #1;
    chk("rst_stall", {31'd0, STALL}, 32'd0);
    chk("rst_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd0);
    chk("rst_wrreq", {31'd0, DMEM_WRREQ_VALID}, 32'd0);
    chk("rst_rdaddr", DMEM_RDREQ_ADDR, 32'd0);
    chk("rst_wrdata", DMEM_WRREQ_DATA, 32'd0);
    chk("rst_rd", {27'd0, MEM_REG_W_RD}, 32'd0);
    chk("rst_data", MEM_REG_W_DATA, 32'd0);

    // Clean inputs, release reset.
    clr_mem; FLUSH = 1'b0;
    DMEM_RDREQ_READY = 1'b0; DMEM_RDDATA_VALID = 1'b0; DMEM_WRREQ_READY = 1'b0;
    CUSHION_REG_W_RD = 5'd0; CUSHION_REG_W_DATA = 32'd0;
    RST = 1'b1;
    tick;

    // ALU passthrough.
    CUSHION_REG_W_RD = 5'd5; CUSHION_REG_W_DATA = 32'h1234;
    tick; #1;
    chk("pass_rd", {27'd0, MEM_REG_W_RD}, 32'd5);
    chk("pass_data", MEM_REG_W_DATA, 32'h1234);
    chk("pass_stall", {31'd0, STALL}, 32'd0);
    CUSHION_REG_W_RD = 5'd0;

    // Signed byte load, memory ready immediately.
    hs0 = rd_hs;
    set_load(5'd3, 32'h100, 4'b0100, 1'b1);
    DMEM_RDREQ_READY = 1'b1; DMEM_RDDATA_VALID = 1'b1; DMEM_RDDATA = 32'h0080_0000;
    #1;
    chk("sb_stall_c0", {31'd0, STALL}, 32'd1);
    tick; clr_mem; #1;
    chk("sb_rdreq_c1", {31'd0, DMEM_RDREQ_VALID}, 32'd1);
    chk("sb_addr_c1", DMEM_RDREQ_ADDR, 32'h100);
    chk("sb_stall_c1", {31'd0, STALL}, 32'd1);
    tick; #1;
    chk("sb_rdreq_c2", {31'd0, DMEM_RDREQ_VALID}, 32'd0);
    chk("sb_stall_c2", {31'd0, STALL}, 32'd1);
    CUSHION_REG_W_RD = 5'd7;  // ignored during DONE
    tick; #1;
    chk("sb_stall_done", {31'd0, STALL}, 32'd0);
    chk("sb_rd", {27'd0, MEM_REG_W_RD}, 32'd3);
    chk("sb_data", MEM_REG_W_DATA, 32'hFFFF_FF80);
    tick; #1;
    chk("sb_rd_after", {27'd0, MEM_REG_W_RD}, 32'd0);
    chk("sb_hs", rd_hs - hs0, 32'd1);
    CUSHION_REG_W_RD = 5'd0;
    DMEM_RDREQ_READY = 1'b0; DMEM_RDDATA_VALID = 1'b0;
    tick;

    // Back-pressure: READY low 4 cycles, data 3 cycles late.
    hs0 = rd_hs;
    set_load(5'd9, 32'h200, 4'b1111, 1'b0);
    tick; clr_mem;
    CUSHION_MEM_R_ADDR = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd1);
      chk("bp_addr", DMEM_RDREQ_ADDR, 32'h200);
      chk("bp_stall", {31'd0, STALL}, 32'd1);
      tick;
    end
    DMEM_RDREQ_READY = 1'b1;
    tick;
    DMEM_RDREQ_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bpw_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd0);
      chk("bpw_stall", {31'd0, STALL}, 32'd1);
      tick;
    end
    DMEM_RDDATA_VALID = 1'b1; DMEM_RDDATA = 32'hCAFE_F00D;
    tick; DMEM_RDDATA_VALID = 1'b0; #1;
    chk("bp_rd", {27'd0, MEM_REG_W_RD}, 32'd9);
    chk("bp_data", MEM_REG_W_DATA, 32'hCAFE_F00D);
    chk("bp_stall_done", {31'd0, STALL}, 32'd0);
    chk("bp_hs", rd_hs - hs0, 32'd1);
    tick;

    // Unsigned half load combined with a store.
    hs0 = wr_hs;
    set_load(5'd4, 32'h300, 4'b1100, 1'b0);
    CUSHION_MEM_W_VALID = 1'b1; CUSHION_MEM_W_ADDR = 32'h404;
    CUSHION_MEM_W_STRB = 4'b0011; CUSHION_MEM_W_DATA = 32'h0000_5A5A;
    DMEM_RDREQ_READY = 1'b1; DMEM_WRREQ_READY = 1'b1;
    DMEM_RDDATA_VALID = 1'b1; DMEM_RDDATA = 32'hBEEF_0000;
    tick; clr_mem; #1;
    chk("rw_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd1);
    chk("rw_wrreq_early", {31'd0, DMEM_WRREQ_VALID}, 32'd0);
    tick; tick; #1;
    chk("rw_wrreq", {31'd0, DMEM_WRREQ_VALID}, 32'd1);
    chk("rw_waddr", DMEM_WRREQ_ADDR, 32'h404);
    chk("rw_wstrb", {28'd0, DMEM_WRREQ_STRB}, 32'h3);
    chk("rw_wdata", DMEM_WRREQ_DATA, 32'h0000_5A5A);
    chk("rw_rd", {27'd0, MEM_REG_W_RD}, 32'd4);
    chk("rw_data", MEM_REG_W_DATA, 32'h0000_BEEF);
    chk("rw_stall_wreq", {31'd0, STALL}, 32'd1);
    tick; #1;
    chk("rw_stall_done", {31'd0, STALL}, 32'd0);
    chk("rw_wrreq_done", {31'd0, DMEM_WRREQ_VALID}, 32'd0);
    chk("rw_whs", wr_hs - hs0, 32'd1);
    tick;
    DMEM_RDREQ_READY = 1'b0; DMEM_WRREQ_READY = 1'b0; DMEM_RDDATA_VALID = 1'b0;

    // Extraction shapes: unsigned byte lane 1, signed half, odd mask raw.
    quick_load("ub1", 4'b0010, 1'b0, 32'h1234_A5FF, 32'h0000_00A5);
    quick_load("sh0", 4'b0011, 1'b1, 32'h0000_8001, 32'hFFFF_8001);
    quick_load("raw", 4'b0110, 1'b1, 32'h89AB_CDEF, 32'h89AB_CDEF);

    // Flush during RWAIT: handshake completes, rd killed.
    hs0 = rd_hs;
    set_load(5'd6, 32'h600, 4'b0001, 1'b1);
    DMEM_RDREQ_READY = 1'b1; DMEM_RDDATA = 32'h0000_00FF;
    tick; clr_mem;
    tick;
    FLUSH = 1'b1;
    tick;
    FLUSH = 1'b0; DMEM_RDDATA_VALID = 1'b1;
    tick; DMEM_RDDATA_VALID = 1'b0; #1;
    chk("fr_rd", {27'd0, MEM_REG_W_RD}, 32'd0);
    chk("fr_data", MEM_REG_W_DATA, 32'hFFFF_FFFF);
    chk("fr_stall", {31'd0, STALL}, 32'd0);
    chk("fr_hs", rd_hs - hs0, 32'd1);
    tick;
    DMEM_RDREQ_READY = 1'b0;

    // Flush during WREQ: write still issued exactly once.
    hs0 = wr_hs;
    CUSHION_MEM_W_VALID = 1'b1; CUSHION_MEM_W_ADDR = 32'h500;
    CUSHION_MEM_W_STRB = 4'b1111; CUSHION_MEM_W_DATA = 32'h1122_3344;
    tick; clr_mem;
    FLUSH = 1'b1; #1;
    chk("fw_wrreq", {31'd0, DMEM_WRREQ_VALID}, 32'd1);
    tick; FLUSH = 1'b0; #1;
    chk("fw_wrreq_held", {31'd0, DMEM_WRREQ_VALID}, 32'd1);
    chk("fw_wdata", DMEM_WRREQ_DATA, 32'h1122_3344);
    DMEM_WRREQ_READY = 1'b1;
    tick; DMEM_WRREQ_READY = 1'b0; #1;
    chk("fw_stall_done", {31'd0, STALL}, 32'd0);
    tick; tick; #1;
    chk("fw_whs", wr_hs - hs0, 32'd1);

    // Flush in IDLE: no request latched, writeback cleared.
    set_load(5'd2, 32'h700, 4'b1111, 1'b0);
    FLUSH = 1'b1; CUSHION_REG_W_RD = 5'd8; CUSHION_REG_W_DATA = 32'h88;
    tick; clr_mem; FLUSH = 1'b0; #1;
    chk("fi_rd", {27'd0, MEM_REG_W_RD}, 32'd0);
    chk("fi_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd0);
    tick; #1;
    chk("fi_pass_rd", {27'd0, MEM_REG_W_RD}, 32'd8);
    chk("fi_pass_data", MEM_REG_W_DATA, 32'h88);
    CUSHION_REG_W_RD = 5'd0;

    // Reset mid-transaction abandons the request.
    set_load(5'd1, 32'h800, 4'b1111, 1'b0);
    tick; clr_mem; #1;
    chk("mr_rdreq", {31'd0, DMEM_RDREQ_VALID}, 32'd1);
    RST = 1'b0;
    tick; #1;
    chk("mr_rdreq_rst", {31'd0, DMEM_RDREQ_VALID}, 32'd0);
    chk("mr_addr_rst", DMEM_RDREQ_ADDR, 32'd0);
    RST = 1'b1;
    tick; #1;
    chk("mr_stall", {31'd0, STALL}, 32'd0);
    chk("mr_rdreq_after", {31'd0, DMEM_RDREQ_VALID}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
